// File: rtl/paddle_kbd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : paddle_kbd_pkg
// Brief    : Scan-code constants, decoder state type and frame helper shared
//            by the PS/2 receiver and the paddle key decoder.
// Revision : 1.0 - initial release
// ============================================================================
package paddle_kbd_pkg;

  // Set-2 scan codes the game reacts to
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_BAT   = 8'hAA;
  localparam logic [7:0] SC_ERR   = 8'hFC;

  // Prefix tracking: which of E0 / F0 have been seen for the current key
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } dec_state_e;

  // Odd parity holds when data plus parity bit carry an odd number of ones
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage
`default_nettype wire

// File: rtl/paddle_key_decoder_ps2_rx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_rx
// Brief    : PS/2 device-to-host receiver. Synchronizes and glitch-filters the
//            PS/2 clock, shifts in 11-bit frames on filtered falling edges and
//            reports each frame as either a valid byte or a framing error.
//            A stalled frame is silently discarded after a timeout.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_rx
  import paddle_kbd_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int FILT_W = $clog2(FILTER_LEN + 1);
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0] STOP_IDX = 4'd10;

  logic [1:0]        clk_sync_q;
  logic [1:0]        dat_sync_q;
  logic              filt_q;
  logic              filt_prev_q;
  logic [FILT_W-1:0] filt_cnt_q;
  logic [3:0]        bit_cnt_q;
  logic [9:0]        shift_q;
  logic [TMO_W-1:0]  tmo_cnt_q;
  logic [7:0]        byte_q;
  logic              valid_q;
  logic              err_q;
  logic              fall_edge;
  logic              sample_bit;
  logic              frame_ok;

  // Two-flop synchronizers; idle-high reset value avoids a fake edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[0], ps2_data_i};
    end
  end

  // Filtered clock only follows the pin after FILTER_LEN agreeing samples
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      filt_cnt_q  <= '0;
    end else begin
      filt_prev_q <= filt_q;
      if (clk_sync_q[1] == filt_q) begin
        filt_cnt_q <= '0;
      end else if (filt_cnt_q == FILT_W'(FILTER_LEN - 1)) begin
        filt_q     <= clk_sync_q[1];
        filt_cnt_q <= '0;
      end else begin
        filt_cnt_q <= filt_cnt_q + 1'b1;
      end
    end
  end

  assign fall_edge  = filt_prev_q & ~filt_q;
  assign sample_bit = dat_sync_q[1];

  // shift_q[0] is the start bit, [8:1] the data, [9] the parity once ten
  // bits are in; the stop bit is the live sample at the eleventh edge.
  assign frame_ok = ~shift_q[0] & odd_parity_ok(shift_q[8:1], shift_q[9]) & sample_bit;

  // Frame assembly, end-of-frame verdict and mid-frame stall timeout
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tmo_cnt_q <= '0;
      byte_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (fall_edge) begin
        tmo_cnt_q <= '0;
        if (bit_cnt_q == STOP_IDX) begin
          bit_cnt_q <= '0;
          if (frame_ok) begin
            valid_q <= 1'b1;
            byte_q  <= shift_q[8:1];
          end else begin
            err_q <= 1'b1;
          end
        end else begin
          shift_q   <= {sample_bit, shift_q[9:1]};
          bit_cnt_q <= bit_cnt_q + 4'd1;
        end
      end else if (bit_cnt_q != 4'd0) begin
        if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          bit_cnt_q <= '0;
          tmo_cnt_q <= '0;
        end else begin
          tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
      end else begin
        tmo_cnt_q <= '0;
      end
    end
  end

  assign byte_o       = byte_q;
  assign byte_valid_o = valid_q;
  assign frame_err_o  = err_q;

endmodule
`default_nettype wire

// File: rtl/paddle_key_decoder.sv
`default_nettype none
// ============================================================================
// Module   : paddle_key_decoder
// Brief    : PS/2 keyboard to paddle commands. Tracks make/break (and
//            E0-extended) scan codes into held-key flags and drives per-player
//            up/down levels plus a start pulse on a fresh Space press.
// Revision : 1.0 - initial release
// ============================================================================
module paddle_key_decoder
  import paddle_kbd_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic p1_up,
  output logic p1_down,
  output logic p2_up,
  output logic p2_down,
  output logic start_pulse,
  output logic frame_err
);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_err;

  dec_state_e state_q;
  logic       w_q;
  logic       s_q;
  logic       space_q;
  logic       up_q;
  logic       dn_q;
  logic       space_prev_q;
  logic       p1_up_q;
  logic       p1_down_q;
  logic       p2_up_q;
  logic       p2_down_q;
  logic       start_q;
  logic       frame_err_q;

  ps2_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk          (clk),
    .reset        (reset),
    .ps2_clk_i    (ps2_clk),
    .ps2_data_i   (ps2_data),
    .byte_o       (rx_byte),
    .byte_valid_o (rx_valid),
    .frame_err_o  (rx_err)
  );

  // Prefix FSM and held-key flags; a bad frame drops any pending prefix
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      w_q     <= 1'b0;
      s_q     <= 1'b0;
      space_q <= 1'b0;
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
    end else if (rx_err) begin
      state_q <= ST_IDLE;
    end else if (rx_valid) begin
      if (rx_byte == SC_EXT) begin
        state_q <= ST_EXT;
      end else if (rx_byte == SC_BRK) begin
        case (state_q)
          ST_EXT, ST_EXT_BRK: state_q <= ST_EXT_BRK;
          default:            state_q <= ST_BRK;
        endcase
      end else begin
        state_q <= ST_IDLE;
        case (state_q)
          ST_IDLE: begin
            case (rx_byte)
              SC_W:     w_q     <= 1'b1;
              SC_S:     s_q     <= 1'b1;
              SC_SPACE: space_q <= 1'b1;
              SC_BAT, SC_ERR: begin
                w_q     <= 1'b0;
                s_q     <= 1'b0;
                space_q <= 1'b0;
                up_q    <= 1'b0;
                dn_q    <= 1'b0;
              end
              default: ;
            endcase
          end
          ST_BRK: begin
            case (rx_byte)
              SC_W:     w_q     <= 1'b0;
              SC_S:     s_q     <= 1'b0;
              SC_SPACE: space_q <= 1'b0;
              default: ;
            endcase
          end
          ST_EXT: begin
            case (rx_byte)
              SC_UP:   up_q <= 1'b1;
              SC_DOWN: dn_q <= 1'b1;
              default: ;
            endcase
          end
          ST_EXT_BRK: begin
            case (rx_byte)
              SC_UP:   up_q <= 1'b0;
              SC_DOWN: dn_q <= 1'b0;
              default: ;
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  // Registered outputs; opposing keys cancel, Space pulses on its rising flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      space_prev_q <= 1'b0;
      p1_up_q      <= 1'b0;
      p1_down_q    <= 1'b0;
      p2_up_q      <= 1'b0;
      p2_down_q    <= 1'b0;
      start_q      <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      space_prev_q <= space_q;
      p1_up_q      <= w_q & ~s_q;
      p1_down_q    <= s_q & ~w_q;
      p2_up_q      <= up_q & ~dn_q;
      p2_down_q    <= dn_q & ~up_q;
      start_q      <= space_q & ~space_prev_q;
      frame_err_q  <= rx_err;
    end
  end

  assign p1_up       = p1_up_q;
  assign p1_down     = p1_down_q;
  assign p2_up       = p2_up_q;
  assign p2_down     = p2_down_q;
  assign start_pulse = start_q;
  assign frame_err   = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_paddle_key_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_paddle_key_decoder
// Brief    : Directed and randomized PS/2 frame stimulus against a key-state
//            reference model for paddle_key_decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_paddle_key_decoder;

  localparam int TB_TIMEOUT = 300;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic p1_up, p1_down, p2_up, p2_down, start_pulse, frame_err;

  int total = 0;
  int bad = 0;
  int sp_cnt = 0;
  int err_cnt = 0;

  // reference model: held keys, pending prefixes, expected pulse counts
  bit m_w, m_s, m_sp, m_up, m_dn, m_ext, m_brk;
  int exp_start = 0;
  int exp_err = 0;

  paddle_key_decoder #(
    .FILTER_LEN     (8),
    .TIMEOUT_CYCLES (TB_TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .p1_up       (p1_up),
    .p1_down     (p1_down),
    .p2_up       (p2_up),
    .p2_down     (p2_down),
    .start_pulse (start_pulse),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  // count high cycles of the pulse outputs
  always @(negedge clk) begin
    if (start_pulse === 1'b1) sp_cnt++;
    if (frame_err === 1'b1) err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_w = 0; m_s = 0; m_sp = 0; m_up = 0; m_dn = 0; m_ext = 0; m_brk = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hE0) begin
      m_ext = 1; m_brk = 0;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      if (!m_ext && !m_brk) begin
        if (b == 8'h1D) m_w = 1;
        if (b == 8'h1B) m_s = 1;
        if (b == 8'h29) begin
          if (!m_sp) exp_start++;
          m_sp = 1;
        end
        if (b == 8'hAA || b == 8'hFC) begin
          m_w = 0; m_s = 0; m_sp = 0; m_up = 0; m_dn = 0;
        end
      end else if (!m_ext && m_brk) begin
        if (b == 8'h1D) m_w = 0;
        if (b == 8'h1B) m_s = 0;
        if (b == 8'h29) m_sp = 0;
      end else if (m_ext && !m_brk) begin
        if (b == 8'h75) m_up = 1;
        if (b == 8'h72) m_dn = 1;
      end else begin
        if (b == 8'h75) m_up = 0;
        if (b == 8'h72) m_dn = 0;
      end
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".p1_up"},   {31'd0, p1_up},   {31'd0, m_w & ~m_s});
    chk({tag, ".p1_down"}, {31'd0, p1_down}, {31'd0, m_s & ~m_w});
    chk({tag, ".p2_up"},   {31'd0, p2_up},   {31'd0, m_up & ~m_dn});
    chk({tag, ".p2_down"}, {31'd0, p2_down}, {31'd0, m_dn & ~m_up});
    chk({tag, ".starts"},  sp_cnt,  exp_start);
    chk({tag, ".errs"},    err_cnt, exp_err);
  endtask

  // drive the first n bits of an 11-bit frame, LSB (start) first
  task automatic drive_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      repeat (10) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (20) @(posedge clk);
      ps2_clk = 1'b1;
      repeat (10) @(posedge clk);
    end
    ps2_data = 1'b1;
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad_par);
    logic par;
    par = ~(^b) ^ bad_par;
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic send(input logic [7:0] b, input bit bad_par, input string tag);
    drive_bits(make_frame(b, bad_par), 11);
    repeat (40) @(posedge clk);
    #1;
    if (bad_par) begin
      m_ext = 0; m_brk = 0; exp_err++;
    end else begin
      model_byte(b);
    end
    check_outputs(tag);
  endtask

  logic [7:0] pool [10] = '{8'h1D, 8'h1B, 8'h29, 8'h75, 8'h72, 8'hE0, 8'hF0, 8'hAA, 8'hFC, 8'h00};

  initial begin
    int s0;
    int e0;
    logic [7:0] rb;
    bit rbad;
    model_reset();
    repeat (5) @(posedge clk);
    #1;
    chk("rst.p1_up", {31'd0, p1_up}, 32'd0);
    chk("rst.p1_down", {31'd0, p1_down}, 32'd0);
    chk("rst.p2_up", {31'd0, p2_up}, 32'd0);
    chk("rst.p2_down", {31'd0, p2_down}, 32'd0);
    chk("rst.start", {31'd0, start_pulse}, 32'd0);
    chk("rst.err", {31'd0, frame_err}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(posedge clk);

    // W make / break
    send(8'h1D, 0, "w_make");
    chk("w_make.level", {31'd0, p1_up}, 32'd1);
    send(8'hF0, 0, "w_f0");
    send(8'h1D, 0, "w_break");
    chk("w_break.level", {31'd0, p1_up}, 32'd0);

    // extended up make / break
    send(8'hE0, 0, "up_e0");
    send(8'h75, 0, "up_make");
    chk("up_make.level", {31'd0, p2_up}, 32'd1);
    send(8'hE0, 0, "up_e0b");
    send(8'hF0, 0, "up_f0");
    send(8'h75, 0, "up_break");
    chk("up_break.level", {31'd0, p2_up}, 32'd0);

    // both W and S held cancel, releasing W leaves S
    send(8'h1D, 0, "ws_w");
    send(8'h1B, 0, "ws_s");
    chk("ws_both.p1_up", {31'd0, p1_up}, 32'd0);
    chk("ws_both.p1_down", {31'd0, p1_down}, 32'd0);
    send(8'hF0, 0, "ws_f0");
    send(8'h1D, 0, "ws_wrel");
    chk("ws_wrel.p1_down", {31'd0, p1_down}, 32'd1);
    send(8'hF0, 0, "ws_f0b");
    send(8'h1B, 0, "ws_srel");

    // typematic Space: only fresh presses pulse
    s0 = sp_cnt;
    send(8'h29, 0, "sp1");
    send(8'h29, 0, "sp2");
    send(8'h29, 0, "sp3");
    send(8'hF0, 0, "sp_f0");
    send(8'h29, 0, "sp_rel");
    send(8'h29, 0, "sp4");
    chk("space.pulses", sp_cnt - s0, 32'd2);
    send(8'hF0, 0, "sp_f0b");
    send(8'h29, 0, "sp_rel2");

    // parity error is rejected, then a good frame works
    e0 = err_cnt;
    send(8'h1D, 1, "par_bad");
    chk("par_bad.pulse", err_cnt - e0, 32'd1);
    chk("par_bad.p1_up", {31'd0, p1_up}, 32'd0);
    send(8'h1D, 0, "par_good");
    chk("par_good.p1_up", {31'd0, p1_up}, 32'd1);
    send(8'hF0, 0, "par_f0");
    send(8'h1D, 0, "par_rel");

    // stalled frame times out silently, next frame decodes cleanly
    e0 = err_cnt;
    drive_bits(make_frame(8'h1B, 0), 5);
    repeat (TB_TIMEOUT + 100) @(posedge clk);
    send(8'h1B, 0, "tmo_s");
    chk("tmo.p1_down", {31'd0, p1_down}, 32'd1);
    chk("tmo.no_err", err_cnt - e0, 32'd0);
    send(8'hF0, 0, "tmo_f0");
    send(8'h1B, 0, "tmo_rel");

    // asynchronous reset with W held
    send(8'h1D, 0, "ar_w");
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    chk("areset.p1_up", {31'd0, p1_up}, 32'd0);
    check_outputs("areset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(posedge clk);

    // BAT code clears everything held
    send(8'h1D, 0, "bat_w");
    send(8'hE0, 0, "bat_e0");
    send(8'h75, 0, "bat_up");
    send(8'hAA, 0, "bat");
    chk("bat.p1_up", {31'd0, p1_up}, 32'd0);
    chk("bat.p2_up", {31'd0, p2_up}, 32'd0);

    // randomized traffic against the model
    for (int i = 0; i < 40; i++) begin
      rb = pool[$urandom_range(0, 9)];
      if (rb == 8'h00) rb = 8'($urandom_range(0, 255));
      rbad = ($urandom_range(0, 9) == 0);
      send(rb, rbad, $sformatf("rnd%0d_%02h", i, rb));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/paddle_key_decoder.md
Name: paddle_key_decoder

Overview:
Turns a PS/2 keyboard into the per-player up/down level commands that drive the two paddle position blocks. It receives raw PS/2 frames, validates them, and tracks make/break scan codes, including E0-extended codes, in a small FSM. It outputs held-key levels for player 1 (W/S) and player 2 (arrow up/down), plus a one-cycle start pulse on Space. It sits between the board PS/2 pins and the game logic, in the clk domain.

Parameters:
FILTER_LEN, 8, consecutive identical synchronized ps2_clk samples required to change the filtered clock
TIMEOUT_CYCLES, 100000, clk cycles without a falling edge mid-frame before the frame is aborted (1 ms at 100 MHz)

Ports:
clk  input  1  system clock (100 MHz)
reset  input  1  asynchronous, active-high reset
ps2_clk  input  1  raw PS/2 clock pin (asynchronous)
ps2_data  input  1  raw PS/2 data pin (asynchronous)
p1_up  output  1  W held (masked, see below)
p1_down  output  1  S held (masked)
p2_up  output  1  arrow-up held (masked)
p2_down  output  1  arrow-down held (masked)
start_pulse  output  1  one-cycle pulse on a Space make after Space was released
frame_err  output  1  one-cycle pulse on a bad start, parity or stop bit

Behaviour:
Reset and clock:
- reset is asynchronous, active-high; clock is clk.
- On reset, every output is 0, all key-held flags are 0, the decoder FSM is in IDLE, the receiver is idle, and the filtered clock is 1.

Receiver front end:
- ps2_clk and ps2_data each pass through a 2-FF synchronizer.
- The filtered clock changes only after FILTER_LEN equal consecutive samples.
- A falling edge of the filtered clock samples synchronized data.

Frame reception:
- An 11-bit frame is start(0), d0..d7 (LSB first), odd parity, stop(1).
- On the stop-bit sample, the next cycle carries either byte_valid or frame_err; exactly one of the two pulses for one cycle.
- byte_valid requires start=0, odd parity over d0..d7+p, and stop=1. Otherwise frame_err pulses.
- Mid-frame timeout: if no falling edge occurs for TIMEOUT_CYCLES, the bit counter clears and the receiver returns to idle. No pulse is produced.

Decoder FSM (states IDLE, BRK, EXT, EXT_BRK), acting on byte_valid:
- 0xE0 from any state -> EXT.
- 0xF0: IDLE -> BRK; EXT -> EXT_BRK; BRK stays BRK; EXT_BRK stays EXT_BRK.
- Any other byte: apply its action, then return to IDLE.
- IDLE actions: 0x1D sets w; 0x1B sets s; 0x29 sets space; 0xAA or 0xFC clears all held flags.
- BRK actions: 0x1D clears w; 0x1B clears s; 0x29 clears space.
- EXT actions: 0x75 sets up; 0x72 sets dn.
- EXT_BRK actions: 0x75 clears up; 0x72 clears dn.
- Unknown codes: no flag change, return to IDLE.
- frame_err forces the FSM to IDLE. Held flags are kept.

Outputs:
- Registered, one cycle after the flag update.
- p1_up = w & ~s; p1_down = s & ~w. Both held gives both 0. p2 is the same with up/dn.
- start_pulse fires only when the space flag goes 0 -> 1, so typematic repeats do not re-pulse.

Latency:
- Outputs update 2 clk cycles after the stop-bit sample, plus the synchronizer and filter delay.

Decomposition:
- Shared package paddle_kbd_pkg holds:
  - Scan-code constants SC_W=8'h1D, SC_S=8'h1B, SC_SPACE=8'h29, SC_UP=8'h75, SC_DOWN=8'h72, SC_EXT=8'hE0, SC_BRK=8'hF0, SC_BAT=8'hAA, SC_ERR=8'hFC.
  - The decoder state enum.
- Sub-module ps2_rx contains the synchronizers, filter, frame shift register, parity check and timeout. It outputs byte[7:0], byte_valid and frame_err.

Test Plan:
- Send frame 0x1D (valid parity) -> p1_up=1 two cycles after the stop bit; then send F0,1D -> p1_up=0.
- Send E0,75 -> p2_up=1; then send E0,F0,75 -> p2_up=0; p1 outputs stay 0 throughout.
- Send 1D then 1B -> p1_up=0 and p1_down=0; then send F0,1D -> p1_down=1.
- Send 29 three times (typematic), then F0,29, then 29 -> exactly 2 start_pulse cycles total.
- Send frame 0x1D with parity flipped -> one frame_err pulse, p1_up stays 0; then send a valid 0x1D -> p1_up=1.
- Stop ps2_clk after 5 bits for 100001 cycles, then send a full valid 0x1B -> p1_down=1 with no frame_err. Separately: assert reset while W is held -> all outputs 0 immediately; send AA while W and Up are held -> all outputs 0.
